// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the step/run clock controller: FSM encodings and default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_ctrl_pkg;

    // 10 ms of stable input at a 5 MHz oscillator
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int STATE_W                 = 2;

    // Encodings are shown on the front-panel display, so they are fixed
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_INSTR = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/step_run_controller_if.sv
// CPU-side bus of the step/run controller: PC and breakpoint in, clock enable and status out.
// Latency: wires only.
// Backpressure: none; o_cpuClkEn is the only throttle on the CPU.
// Ports: master = controller (drives o_*), slave = CPU/panel side (drives i_*).
interface step_run_controller_if
    import clock_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] i_breakpointAddress;
    logic [ADDR_WIDTH-1:0] i_pc;
    logic                  i_instrDone;
    logic                  o_cpuClkEn;
    logic                  o_halted;
    logic [STATE_W-1:0]    o_state;

    modport master (
        input  i_breakpointAddress, i_pc, i_instrDone,
        output o_cpuClkEn, o_halted, o_state
    );

    modport slave (
        output i_breakpointAddress, i_pc, i_instrDone,
        input  o_cpuClkEn, o_halted, o_state
    );
endinterface

// File: rtl/input_debouncer.sv
// Synchronizes and debounces one raw asynchronous input into a clean level.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES of stable input before the level moves.
// Backpressure: none.
// Ports: i_clk/i_reset, i_raw (async), o_level (debounced), o_settled (first level decision made).
module input_debouncer
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_settled
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync3_q, sync3_d;
    logic             level_q, level_d;
    logic             settled_q, settled_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_next;
    logic             pending;

    always_comb begin
        sync1_d   = i_raw;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        level_d   = level_q;
        settled_d = settled_q;
        cnt_d     = '0;
        // Until the first decision the reset level is only provisional, so the
        // input must also prove itself stable when it already equals that level.
        pending   = (sync2_q != level_q) || !settled_q;
        // Any movement of the synchronized input restarts the stability window.
        cnt_next  = (sync2_q != sync3_q) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        if (pending) begin
            if (cnt_next == CNT_W'(DEBOUNCE_CYCLES)) begin
                level_d   = sync2_q;
                settled_d = 1'b1;
            end else begin
                cnt_d = cnt_next;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            level_q   <= 1'b0;
            settled_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            level_q   <= level_d;
            settled_q <= settled_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_level   = level_q;
    assign o_settled = settled_q;
endmodule

// File: rtl/step_run_controller.sv
// Front-panel step/run controller: gates the CPU clock for run, cycle step, instruction step and breakpoints.
// Latency: panel inputs act ~DEBOUNCE_CYCLES+3 cycles after they change; CPU-side inputs act next cycle.
// Backpressure: none; the CPU is throttled only through o_cpuClkEn.
// Ports: i_oszClk, i_reset (sync, active-high), four raw panel inputs, cpu (master side of the CPU bus).
module step_run_controller
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                        i_oszClk,
    input  logic                        i_reset,
    input  logic                        i_btnStep,
    input  logic                        i_swStepNRun,
    input  logic                        i_swInstrNCycle,
    input  logic                        i_swEnableBreakpoint,
    step_run_controller_if.master       cpu
);
    logic btn_lvl, step_mode, instr_mode, bp_armed;
    logic btn_ok, step_ok, instr_ok, bp_ok;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .i_clk(i_oszClk), .i_reset(i_reset), .i_raw(i_btnStep),
        .o_level(btn_lvl), .o_settled(btn_ok));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .i_clk(i_oszClk), .i_reset(i_reset), .i_raw(i_swStepNRun),
        .o_level(step_mode), .o_settled(step_ok));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_instr (
        .i_clk(i_oszClk), .i_reset(i_reset), .i_raw(i_swInstrNCycle),
        .o_level(instr_mode), .o_settled(instr_ok));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bp (
        .i_clk(i_oszClk), .i_reset(i_reset), .i_raw(i_swEnableBreakpoint),
        .o_level(bp_armed), .o_settled(bp_ok));

    state_t                state_q, state_d;
    logic                  skip_q, skip_d;
    logic                  step_en_q, step_en_d;
    logic                  press_q, press_d;
    logic                  btn_prev_q, btn_prev_d;
    logic                  btn_seen_q, btn_seen_d;
    logic                  cpu_clk_en, halted, bp_hit, inputs_settled;
    logic [ADDR_WIDTH-1:0] pc_w, bp_addr_w;

    assign pc_w           = cpu.i_pc;
    assign bp_addr_w      = cpu.i_breakpointAddress;
    assign inputs_settled = btn_ok & step_ok & instr_ok & bp_ok;
    // Only RUN and INSTR enable the CPU unconditionally, so enable is implied there.
    assign bp_hit = bp_armed && cpu.i_instrDone && !skip_q && (pc_w == bp_addr_w) &&
                    ((state_q == ST_RUN) || (state_q == ST_INSTR));

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        step_en_d  = 1'b0;
        btn_prev_d = btn_lvl;
        btn_seen_d = btn_ok;
        // The first accepted level after reset is not an edge: a button held
        // through reset must be released and pressed again.
        press_d    = btn_lvl & ~btn_prev_q & btn_seen_q;
        cpu_clk_en = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cpu_clk_en = step_en_q;
                if (!step_mode) begin
                    if (inputs_settled) state_d = ST_RUN;
                end else if (press_q) begin
                    if (instr_mode) state_d   = ST_INSTR;
                    else            step_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                cpu_clk_en = 1'b1;
                if (cpu.i_instrDone) skip_d = 1'b0;
                if (bp_hit)         state_d = ST_HALT;
                else if (step_mode) state_d = ST_IDLE;
            end
            ST_INSTR: begin
                cpu_clk_en = 1'b1;
                if (cpu.i_instrDone) skip_d = 1'b0;
                if (bp_hit)                state_d = ST_HALT;
                else if (!step_mode)       state_d = ST_RUN;
                else if (cpu.i_instrDone)  state_d = ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (!bp_armed) begin
                    state_d = ST_IDLE;
                end else if (press_q) begin
                    state_d = step_mode ? ST_INSTR : ST_RUN;
                    // PC still sits on the breakpoint; let the next instruction finish.
                    skip_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_oszClk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            skip_q     <= 1'b0;
            step_en_q  <= 1'b0;
            press_q    <= 1'b0;
            btn_prev_q <= 1'b0;
            btn_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            step_en_q  <= step_en_d;
            press_q    <= press_d;
            btn_prev_q <= btn_prev_d;
            btn_seen_q <= btn_seen_d;
        end
    end

    assign cpu.o_cpuClkEn = cpu_clk_en;
    assign cpu.o_halted   = halted;
    assign cpu.o_state    = state_q;
endmodule

// File: tb/tb_step_run_controller.sv
module tb_step_run_controller;
    import clock_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst, btn, sw_step, sw_instr, sw_bp;
    int   checks = 0;
    int   passed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs, exp_v;

    always #5 clk = ~clk;

    step_run_controller_if #(.ADDR_WIDTH(16)) bus ();

    step_run_controller #(.DEBOUNCE_CYCLES(4), .ADDR_WIDTH(16)) dut (
        .i_oszClk(clk), .i_reset(rst), .i_btnStep(btn), .i_swStepNRun(sw_step),
        .i_swInstrNCycle(sw_instr), .i_swEnableBreakpoint(sw_bp), .cpu(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget);
        for (int i = 0; i < budget && bus.o_state !== st; i++) tick();
    endtask

    task automatic test_reset();
        int highs;
        rst = 1'b1; btn = 1'b0; sw_step = 1'b1; sw_instr = 1'b0; sw_bp = 1'b0;
        bus.i_pc = 16'h0000; bus.i_instrDone = 1'b0; bus.i_breakpointAddress = 16'h00ff;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(32'(ST_IDLE));
        repeat (3) tick();
        obs = 32'(bus.o_cpuClkEn); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL reset_en: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_halted); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL reset_halted: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL reset_state: got %0d expected %0d", obs, exp_v); else passed++;
        rst = 1'b0;
        exp_q.push_back(0); exp_q.push_back(32'(ST_IDLE));
        highs = 0;
        repeat (12) begin tick(); if (bus.o_cpuClkEn !== 1'b0) highs++; end
        obs = 32'(highs); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL settle_en_cycles: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL settle_state: got %0d expected %0d", obs, exp_v); else passed++;
    endtask

    task automatic test_step_cycle();
        int highs, pulses;
        logic prev;
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(32'(ST_IDLE));
        highs = 0; pulses = 0; prev = 1'b0;
        for (int n = 0; n < 41; n++) begin
            if (n < 9) btn = ((n % 3) != 2);  // three short bounces
            else       btn = (n < 29);        // then held 20 cycles, released
            tick();
            if (bus.o_cpuClkEn === 1'b1) begin highs++; if (!prev) pulses++; end
            prev = (bus.o_cpuClkEn === 1'b1);
        end
        obs = 32'(pulses); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL step_pulses: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(highs); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL step_width: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL step_state: got %0d expected %0d", obs, exp_v); else passed++;
    endtask

    task automatic test_instr_step();
        int cnt;
        sw_instr = 1'b1;
        repeat (8) tick();
        exp_q.push_back(5); exp_q.push_back(32'(ST_IDLE));
        btn = 1'b1; cnt = 0;
        repeat (30) begin
            tick();
            bus.i_instrDone = 1'b0;
            if (bus.o_cpuClkEn === 1'b1) begin
                cnt++;
                if (cnt == 5) bus.i_instrDone = 1'b1;
            end
        end
        obs = 32'(cnt); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL instr_en_cycles: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL instr_end_state: got %0d expected %0d", obs, exp_v); else passed++;
        btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_breakpoint();
        sw_instr = 1'b0; sw_bp = 1'b1; sw_step = 1'b0; bus.i_pc = 16'h01ff;
        exp_q.push_back(32'(ST_RUN)); exp_q.push_back(1);
        repeat (10) tick();
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL run_state: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_cpuClkEn); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL run_en: got %0d expected %0d", obs, exp_v); else passed++;
        // Upper address bit differs: full-width compare must not match
        exp_q.push_back(32'(ST_RUN));
        bus.i_instrDone = 1'b1; tick(); bus.i_instrDone = 1'b0;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL bp_near_miss: got %0d expected %0d", obs, exp_v); else passed++;
        exp_q.push_back(32'(ST_HALT)); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(32'(ST_HALT));
        bus.i_pc = 16'h00ff; bus.i_instrDone = 1'b1; tick(); bus.i_instrDone = 1'b0;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL bp_state: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_halted); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL bp_halted: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_cpuClkEn); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL bp_en: got %0d expected %0d", obs, exp_v); else passed++;
        repeat (3) tick();
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL bp_hold: got %0d expected %0d", obs, exp_v); else passed++;
    endtask

    task automatic test_resume();
        exp_q.push_back(32'(ST_RUN)); exp_q.push_back(32'(ST_RUN)); exp_q.push_back(32'(ST_HALT));
        btn = 1'b1;
        wait_state(2'(ST_RUN), 15);
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL resume_state: got %0d expected %0d", obs, exp_v); else passed++;
        bus.i_instrDone = 1'b1; tick(); bus.i_instrDone = 1'b0;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL resume_skip: got %0d expected %0d", obs, exp_v); else passed++;
        bus.i_instrDone = 1'b1; tick(); bus.i_instrDone = 1'b0;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL rehit_state: got %0d expected %0d", obs, exp_v); else passed++;
        btn = 1'b0;
        repeat (8) tick();
        exp_q.push_back(32'(ST_RUN)); exp_q.push_back(0);
        sw_bp = 1'b0;
        wait_state(2'(ST_RUN), 15);
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL disarm_state: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_halted); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL disarm_halted: got %0d expected %0d", obs, exp_v); else passed++;
    endtask

    task automatic test_run_to_step();
        int lat;
        exp_q.push_back(1); exp_q.push_back(32'(ST_IDLE));
        sw_step = 1'b1; lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (lat == 0 && bus.o_cpuClkEn === 1'b0) lat = i;
        end
        obs = 32'((lat > 0) && (lat <= 8)); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL run_to_step_latency: got %0d expected %0d (lat=%0d)", obs, exp_v, lat); else passed++;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL run_to_step_state: got %0d expected %0d", obs, exp_v); else passed++;
    endtask

    task automatic test_mid_reset();
        int highs;
        sw_instr = 1'b1;
        repeat (8) tick();
        exp_q.push_back(32'(ST_INSTR));
        btn = 1'b1;
        wait_state(2'(ST_INSTR), 15);
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL pre_reset_state: got %0d expected %0d", obs, exp_v); else passed++;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(32'(ST_IDLE));
        rst = 1'b1; tick();
        obs = 32'(bus.o_cpuClkEn); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL midrst_en: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_halted); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL midrst_halted: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL midrst_state: got %0d expected %0d", obs, exp_v); else passed++;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.push_back(0); exp_q.push_back(32'(ST_IDLE));
        highs = 0;
        repeat (15) begin tick(); if (bus.o_cpuClkEn !== 1'b0) highs++; end
        obs = 32'(highs); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL held_press_en: got %0d expected %0d", obs, exp_v); else passed++;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL held_press_state: got %0d expected %0d", obs, exp_v); else passed++;
        btn = 1'b0;
        repeat (8) tick();
        exp_q.push_back(32'(ST_INSTR)); exp_q.push_back(32'(ST_IDLE));
        btn = 1'b1;
        wait_state(2'(ST_INSTR), 15);
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL repress_state: got %0d expected %0d", obs, exp_v); else passed++;
        btn = 1'b0;
        bus.i_instrDone = 1'b1; tick(); bus.i_instrDone = 1'b0;
        obs = 32'(bus.o_state); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL repress_done_state: got %0d expected %0d", obs, exp_v); else passed++;
    endtask

    initial begin
        test_reset();
        test_step_cycle();
        test_instr_step();
        test_breakpoint();
        test_resume();
        test_run_to_step();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
